exe_mem_pipe: RTL and testbench

Parametrised EX/MEM pipeline stage for the ThinPad CPU datapath: registers the ALU result, store data, destination register and MEM/WB control from EX, and presents them to the MEM stage. Unlike the fixed 16-bit latch it replaces, it adds valid/ready flow control with a 2-entry skid buffer, synchronous flush to a bubble, and EX/MEM forwarding-hit outputs for the ID/EX operand muxes. It sits between the EX stage and the data-memory/SRAM controller.

---
 rtl/exe_mem_pipe_if.sv | 48 ++++
 rtl/exe_mem_pipe.sv | 111 +++++++++++
 tb/tb_exe_mem_pipe.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exe_mem_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mem_pipe_if
//  Purpose  : EX -> EX/MEM stage -> MEM bundle, including the forwarding
//             probe from ID/EX. slave = pipeline stage, master = neighbours.
//  Revision : 1.0  initial release
// ============================================================================
interface exe_mem_pipe_if #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) ();
    logic              flush;
    logic              valid_in;
    logic              ready_out;
    logic [1:0]        controlmem_in;
    logic              controlwb_in;
    logic [DATA_W-1:0] alu_in;
    logic [DATA_W-1:0] wdata_in;
    logic [REG_W-1:0]  wreg_in;
    logic              mem_ready;
    logic              mem_valid;
    logic              memread_out;
    logic              memwrite_out;
    logic              controlwb_out;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] wdata_out;
    logic [REG_W-1:0]  wreg_out;
    logic [REG_W-1:0]  rs_a;
    logic [REG_W-1:0]  rs_b;
    logic              fwd_hit_a;
    logic              fwd_hit_b;
    logic              fwd_is_load;

    modport slave (
        input  flush, valid_in, controlmem_in, controlwb_in, alu_in, wdata_in,
               wreg_in, mem_ready, rs_a, rs_b,
        output ready_out, mem_valid, memread_out, memwrite_out, controlwb_out,
               alu_out, wdata_out, wreg_out, fwd_hit_a, fwd_hit_b, fwd_is_load
    );

    modport master (
        output flush, valid_in, controlmem_in, controlwb_in, alu_in, wdata_in,
               wreg_in, mem_ready, rs_a, rs_b,
        input  ready_out, mem_valid, memread_out, memwrite_out, controlwb_out,
               alu_out, wdata_out, wreg_out, fwd_hit_a, fwd_hit_b, fwd_is_load
    );
endinterface
`default_nettype wire

// File: rtl/exe_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : exe_mem_pipe
//  Purpose  : EX/MEM pipeline register with valid/ready, 2-entry skid buffer,
//             flush-to-bubble and EX/MEM forwarding hits. Falling-edge clocked.
//  Revision : 1.0  initial release
// ============================================================================
module exe_mem_pipe #(
    parameter int              DATA_W  = 16,
    parameter int              REG_W   = 4,
    parameter logic [REG_W-1:0] NOP_REG = {REG_W{1'b1}}
) (
    input logic           clk,
    input logic           rst,
    exe_mem_pipe_if.slave bus
);
    // Entry layout: {memread, memwrite, controlwb, alu, wdata, wreg}
    localparam int         c_ENT_W   = 3 + 2 * DATA_W + REG_W;
    localparam logic [1:0] c_S_EMPTY = 2'd0;
    localparam logic [1:0] c_S_ONE   = 2'd1;
    localparam logic [1:0] c_S_TWO   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_ready;
    logic [c_ENT_W-1:0] r_main;
    logic [c_ENT_W-1:0] r_skid;
    logic [c_ENT_W-1:0] w_in_ent;
    logic [c_ENT_W-1:0] w_main_d;
    logic [c_ENT_W-1:0] w_out_ent;
    logic               w_main_vld;
    logic               w_accept;
    logic               w_drain;
    logic               w_load_main;
    logic               w_load_skid;
    logic               w_main_from_skid;

    assign w_in_ent = {(bus.controlmem_in == 2'b01), (bus.controlmem_in == 2'b10),
                       bus.controlwb_in, bus.alu_in, bus.wdata_in, bus.wreg_in};

    assign w_main_vld = (r_state != c_S_EMPTY);
    assign w_accept   = bus.valid_in & r_ready;
    assign w_drain    = w_main_vld & bus.mem_ready;
    assign w_main_d   = w_main_from_skid ? r_skid : w_in_ent;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (bus.flush) begin
            w_state_nxt = c_S_EMPTY;
        end else begin
            case (r_state)
                c_S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = c_S_ONE;
                        w_load_main = 1'b1;
                    end
                end
                c_S_ONE: begin
                    if (w_accept && w_drain) begin
                        w_load_main = 1'b1;
                    end else if (w_drain) begin
                        w_state_nxt = c_S_EMPTY;
                    end else if (w_accept) begin
                        w_state_nxt = c_S_TWO;
                        w_load_skid = 1'b1;
                    end
                end
                c_S_TWO: begin
                    if (w_drain) begin
                        w_state_nxt      = c_S_ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = c_S_EMPTY;
            endcase
        end
    end

    // Entry payloads need no reset: a bubble is forced on the outputs while EMPTY.
    always_ff @(negedge clk) begin
        if (!rst) begin
            r_state <= c_S_EMPTY;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt != c_S_TWO);
            if (w_load_main) r_main <= w_main_d;
            if (w_load_skid) r_skid <= w_in_ent;
        end
    end

    assign w_out_ent = w_main_vld ? r_main
                                  : {3'b000, {DATA_W{1'b0}}, {DATA_W{1'b0}}, NOP_REG};

    assign bus.ready_out = r_ready;
    assign bus.mem_valid = w_main_vld;
    assign {bus.memread_out, bus.memwrite_out, bus.controlwb_out,
            bus.alu_out, bus.wdata_out, bus.wreg_out} = w_out_ent;

    // Only the main entry is visible to ID/EX; the skid entry is never forwarded.
    assign bus.fwd_hit_a   = w_main_vld & bus.controlwb_out & (bus.wreg_out == bus.rs_a)
                             & (bus.wreg_out != NOP_REG);
    assign bus.fwd_hit_b   = w_main_vld & bus.controlwb_out & (bus.wreg_out == bus.rs_b)
                             & (bus.wreg_out != NOP_REG);
    assign bus.fwd_is_load = w_main_vld & bus.memread_out;
endmodule
`default_nettype wire

// File: tb/tb_exe_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_mem_pipe
//  Purpose  : Directed vector table plus hand sequences and a scoreboarded
//             random stream for exe_mem_pipe.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_mem_pipe;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    exe_mem_pipe_if bus ();
    exe_mem_pipe dut (.clk(clk), .rst(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [1:0]  cm;
        logic        wb;
        logic [15:0] alu;
        logic [15:0] wd;
        logic [3:0]  wreg;
        logic        mr;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [43:0] exp;
    } vec_t;

    vec_t tbl[9];

    function automatic logic [43:0] mk(input logic mv, input logic rdy, input logic rd,
                                       input logic wr, input logic wb, input logic [15:0] alu,
                                       input logic [15:0] wd, input logic [3:0] wreg,
                                       input logic fa, input logic fb, input logic fl);
        return {mv, rdy, rd, wr, wb, alu, wd, wreg, fa, fb, fl};
    endfunction

    function automatic logic [43:0] obs();
        return {bus.mem_valid, bus.ready_out, bus.memread_out, bus.memwrite_out,
                bus.controlwb_out, bus.alu_out, bus.wdata_out, bus.wreg_out,
                bus.fwd_hit_a, bus.fwd_hit_b, bus.fwd_is_load};
    endfunction

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] cm, input logic wb,
                         input logic [15:0] alu, input logic [15:0] wd, input logic [3:0] wreg,
                         input logic mr, input logic fl);
        bus.valid_in      = v;
        bus.controlmem_in = cm;
        bus.controlwb_in  = wb;
        bus.alu_in        = alu;
        bus.wdata_in      = wd;
        bus.wreg_in       = wreg;
        bus.mem_ready     = mr;
        bus.flush         = fl;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Compact view for sequences: {mem_valid, ready_out, alu_out}
    function automatic logic [43:0] vra();
        return {26'd0, bus.mem_valid, bus.ready_out, bus.alu_out};
    endfunction

    function automatic logic [43:0] evra(input logic mv, input logic rdy, input logic [15:0] a);
        return {26'd0, mv, rdy, a};
    endfunction

    logic [15:0] q[$];
    int          m_occ;
    logic        r_v;
    logic        r_mr;
    logic        r_acc;
    logic        r_drn;
    logic [15:0] r_seq;
    logic [15:0] r_head;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.rs_a = 4'h0;
        bus.rs_b = 4'h0;
        drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0);

        tbl[0] = '{1'b1, 2'b01, 1'b1, 16'h1234, 16'h0000, 4'h3, 1'b1, 4'h3, 4'h4,
                   mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 4'h3, 1'b1, 1'b0, 1'b1)};
        tbl[1] = '{1'b1, 2'b10, 1'b0, 16'h0040, 16'hBEEF, 4'h7, 1'b1, 4'h7, 4'h3,
                   mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0040, 16'hBEEF, 4'h7, 1'b0, 1'b0, 1'b0)};
        tbl[2] = '{1'b1, 2'b11, 1'b1, 16'h5555, 16'hAAAA, 4'h5, 1'b1, 4'h5, 4'h5,
                   mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 16'hAAAA, 4'h5, 1'b1, 1'b1, 1'b0)};
        tbl[3] = '{1'b1, 2'b00, 1'b1, 16'h0001, 16'h0002, 4'hF, 1'b1, 4'hF, 4'h5,
                   mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 16'h0002, 4'hF, 1'b0, 1'b0, 1'b0)};
        tbl[4] = '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 4'hF, 4'hF,
                   mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b0)};
        tbl[5] = '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 4'h0, 4'h0,
                   mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b0)};
        tbl[6] = '{1'b1, 2'b01, 1'b1, 16'h0100, 16'h0000, 4'h5, 1'b1, 4'h5, 4'h6,
                   mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 4'h5, 1'b1, 1'b0, 1'b1)};
        tbl[7] = '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 4'h5, 4'h6,
                   mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0100, 16'h0000, 4'h5, 1'b1, 1'b0, 1'b1)};
        tbl[8] = '{1'b0, 2'b00, 1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 4'h5, 4'h6,
                   mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 4'hF, 1'b0, 1'b0, 1'b0)};

        // Reset
        step();
        step();
        bus.rs_a = 4'hF;
        bus.rs_b = 4'hF;
        #1;
        check("reset", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'hF, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].cm, tbl[i].wb, tbl[i].alu, tbl[i].wd, tbl[i].wreg, tbl[i].mr, 1'b0);
            bus.rs_a = tbl[i].ra;
            bus.rs_b = tbl[i].rb;
            step();
            check($sformatf("vec%0d", i), obs(), tbl[i].exp);
        end

        // Backpressure: A held, B in skid, C refused, then A, B in order
        bus.rs_a = 4'h0;
        bus.rs_b = 4'h0;
        drive(1'b1, 2'b01, 1'b0, 16'h000A, 16'h0, 4'h1, 1'b0, 1'b0);
        step();
        check("bp_a_main", vra(), evra(1'b1, 1'b1, 16'h000A));
        drive(1'b1, 2'b10, 1'b0, 16'h000B, 16'h0, 4'h2, 1'b0, 1'b0);
        step();
        check("bp_b_skid", vra(), evra(1'b1, 1'b0, 16'h000A));
        drive(1'b1, 2'b10, 1'b0, 16'h000C, 16'h0, 4'h3, 1'b0, 1'b0);
        step();
        check("bp_c_hold", vra(), evra(1'b1, 1'b0, 16'h000A));
        bus.mem_ready = 1'b1;
        step();
        check("bp_release_b", vra(), evra(1'b1, 1'b1, 16'h000B));
        drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
        check("bp_drained", vra(), evra(1'b0, 1'b1, 16'h0000));

        // Flush while TWO with valid_in high
        drive(1'b1, 2'b01, 1'b1, 16'h000A, 16'h0, 4'h1, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'b10, 1'b1, 16'h000B, 16'h0, 4'h2, 1'b0, 1'b0);
        step();
        check("fl_two", vra(), evra(1'b1, 1'b0, 16'h000A));
        bus.rs_a = 4'hF;
        bus.rs_b = 4'hF;
        drive(1'b1, 2'b01, 1'b1, 16'h000D, 16'h0, 4'h4, 1'b0, 1'b1);
        step();
        check("fl_bubble", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'hF, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
        check("fl_not_captured", vra(), evra(1'b0, 1'b1, 16'h0000));

        // Reset in TWO, then normal pass-through
        drive(1'b1, 2'b01, 1'b1, 16'h000A, 16'h0, 4'h1, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'b10, 1'b1, 16'h000B, 16'h0, 4'h2, 1'b0, 1'b0);
        step();
        check("rst_two", vra(), evra(1'b1, 1'b0, 16'h000A));
        rst = 1'b0;
        drive(1'b1, 2'b01, 1'b1, 16'h000D, 16'h0, 4'h4, 1'b1, 1'b0);
        step();
        check("rst_bubble", obs(), mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 4'hF, 1'b0, 1'b0, 1'b0));
        rst = 1'b1;
        bus.rs_a = 4'h6;
        drive(1'b1, 2'b01, 1'b1, 16'h000E, 16'h0077, 4'h6, 1'b1, 1'b0);
        step();
        check("rst_after", obs(), mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 16'h000E, 16'h0077, 4'h6, 1'b1, 1'b0, 1'b1));
        drive(1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0);
        step();
        check("rst_drain", vra(), evra(1'b0, 1'b1, 16'h0000));

        // Random stream against a scoreboard queue
        m_occ = 0;
        r_seq = 16'h1000;
        for (int c = 0; c < 1000; c++) begin
            r_v  = 1'($urandom_range(0, 1));
            r_mr = 1'($urandom_range(0, 1));
            drive(r_v, 2'($urandom_range(0, 3)), 1'b0, r_seq, 16'h0, 4'h1, r_mr, 1'b0);
            r_acc = r_v & (m_occ != 2);
            r_drn = (m_occ != 0) & r_mr;
            #1;
            if (r_drn) begin
                r_head = q.pop_front();
                check("rnd_order", {28'd0, bus.alu_out}, {28'd0, r_head});
            end
            if (r_acc) begin
                q.push_back(r_seq);
                r_seq = r_seq + 16'd1;
            end
            m_occ = m_occ + int'(r_acc) - int'(r_drn);
            step();
            check("rnd_occ", {42'd0, bus.mem_valid, bus.ready_out},
                  {42'd0, (m_occ != 0), (m_occ != 2)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
